// File: rtl/traffic_ctrl_nway_pkg.sv
// Shared phase encodings and default timing for the N-way intersection controller.
package traffic_ctrl_nway_pkg;

    typedef enum logic [1:0] {
        PhAllRed = 2'd0,
        PhGreen  = 2'd1,
        PhYellow = 2'd2
    } phase_e;

    localparam int unsigned DEF_NUM_DIR     = 2;
    localparam int unsigned DEF_DIR_W       = 3;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_T_GREEN_MIN = 10;
    localparam int unsigned DEF_T_GREEN_MAX = 40;
    localparam int unsigned DEF_T_YELLOW    = 4;
    localparam int unsigned DEF_T_ALLRED    = 2;

endpackage

// File: rtl/traffic_ctrl_nway_rr_next_dir.sv
// Combinational round-robin picker: next approach to serve, with preemption override.
module rr_next_dir
    import traffic_ctrl_nway_pkg::*;
#(
    parameter int unsigned NUM_DIR = DEF_NUM_DIR,
    parameter int unsigned DIR_W   = DEF_DIR_W
) (
    input  logic [NUM_DIR-1:0] car,
    input  logic [DIR_W-1:0]   active_dir,
    input  logic               preempt_req,
    input  logic [DIR_W-1:0]   preempt_dir,
    output logic [DIR_W-1:0]   next_dir
);

    int unsigned w_cand;

    always_comb begin
        w_cand   = 0;
        next_dir = DIR_W'((32'(active_dir) + 1) % NUM_DIR);
        // Walk from farthest to nearest so the nearest waiting approach wins.
        for (int unsigned i = NUM_DIR; i >= 1; i--) begin
            w_cand = (32'(active_dir) + i) % NUM_DIR;
            for (int unsigned j = 0; j < NUM_DIR; j++) begin
                if (j == w_cand && car[j]) begin
                    next_dir = DIR_W'(j);
                end
            end
        end
        if (preempt_req && (32'(preempt_dir) < NUM_DIR)) begin
            next_dir = preempt_dir;
        end
    end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// N-way intersection controller: all-red / green / yellow sequencing with demand-extended
// green, round-robin service of waiting approaches and emergency preemption.
module traffic_ctrl_nway
    import traffic_ctrl_nway_pkg::*;
#(
    parameter int unsigned NUM_DIR     = DEF_NUM_DIR,
    parameter int unsigned DIR_W       = DEF_DIR_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned T_GREEN_MIN = DEF_T_GREEN_MIN,
    parameter int unsigned T_GREEN_MAX = DEF_T_GREEN_MAX,
    parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
    parameter int unsigned T_ALLRED    = DEF_T_ALLRED
) (
    input  logic               clk,
    input  logic               R,
    input  logic [NUM_DIR-1:0] car,
    input  logic               preempt_req,
    input  logic [DIR_W-1:0]   preempt_dir,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] green,
    output logic [NUM_DIR-1:0] yellow,
    output logic [DIR_W-1:0]   active_dir,
    output logic [1:0]         phase,
    output logic [CNT_W-1:0]   timer
);

    phase_e             r_phase;
    phase_e             w_phase_nxt;
    logic [DIR_W-1:0]   r_dir;
    logic [DIR_W-1:0]   w_dir_nxt;
    logic [DIR_W-1:0]   w_rr_dir;
    logic [CNT_W-1:0]   r_timer;
    logic [NUM_DIR-1:0] w_sel;
    logic               w_pre_valid;
    logic               w_other_car;

    rr_next_dir #(
        .NUM_DIR (NUM_DIR),
        .DIR_W   (DIR_W)
    ) u_rr_next_dir (
        .car         (car),
        .active_dir  (r_dir),
        .preempt_req (preempt_req),
        .preempt_dir (preempt_dir),
        .next_dir    (w_rr_dir)
    );

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            w_sel[i] = (r_dir == DIR_W'(i));
        end
    end

    assign w_pre_valid = preempt_req && (32'(preempt_dir) < NUM_DIR);
    assign w_other_car = |(car & ~w_sel);

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_phase <= PhAllRed;
            r_dir   <= DIR_W'(NUM_DIR - 1);
            r_timer <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_dir   <= w_dir_nxt;
            if (w_phase_nxt != r_phase) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_dir_nxt   = r_dir;
        case (r_phase)
            PhAllRed: begin
                if (r_timer == CNT_W'(T_ALLRED - 1)) begin
                    w_phase_nxt = PhGreen;
                    w_dir_nxt   = w_rr_dir;
                end
            end
            PhGreen: begin
                // A held preemption toward the served approach pins green past the maximum.
                if (w_pre_valid) begin
                    if (preempt_dir != r_dir) begin
                        w_phase_nxt = PhYellow;
                    end
                end else if ((r_timer >= CNT_W'(T_GREEN_MIN - 1) && w_other_car) ||
                             (r_timer >= CNT_W'(T_GREEN_MAX - 1))) begin
                    w_phase_nxt = PhYellow;
                end
            end
            PhYellow: begin
                if (r_timer == CNT_W'(T_YELLOW - 1)) begin
                    w_phase_nxt = PhAllRed;
                end
            end
            default: w_phase_nxt = PhAllRed;
        endcase
    end

    always_comb begin
        red    = '1;
        green  = '0;
        yellow = '0;
        case (r_phase)
            PhGreen: begin
                green = w_sel;
                red   = ~w_sel;
            end
            PhYellow: begin
                yellow = w_sel;
                red    = ~w_sel;
            end
            default: ;
        endcase
    end

    assign active_dir = r_dir;
    assign phase      = r_phase;
    assign timer      = r_timer;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed self-checking bench for traffic_ctrl_nway with four approaches and short timings.
module tb_traffic_ctrl_nway;

    logic       clk = 1'b0;
    logic       R;
    logic [3:0] car;
    logic       preempt_req;
    logic [2:0] preempt_dir;
    logic [3:0] red, green, yellow;
    logic [2:0] active_dir;
    logic [1:0] phase;
    logic [7:0] timer;

    int n_cmp = 0;
    int n_err = 0;

    traffic_ctrl_nway #(
        .NUM_DIR     (4),
        .DIR_W       (3),
        .CNT_W       (8),
        .T_GREEN_MIN (3),
        .T_GREEN_MAX (6),
        .T_YELLOW    (2),
        .T_ALLRED    (1)
    ) dut (
        .clk         (clk),
        .R           (R),
        .car         (car),
        .preempt_req (preempt_req),
        .preempt_dir (preempt_dir),
        .red         (red),
        .green       (green),
        .yellow      (yellow),
        .active_dir  (active_dir),
        .phase       (phase),
        .timer       (timer)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        R = 1'b1; car = 4'b0; preempt_req = 1'b0; preempt_dir = 3'd0;
        step();
        R = 1'b0;
    endtask

    // Expected trace with no demand: 1 all-red + 6 green + 2 yellow per approach, 0,1,2,3,...
    task automatic run_rotation(input string tag, input int ncyc);
        int p, q;
        logic [1:0] eph;
        logic [2:0] edir;
        logic [7:0] etim;
        logic [3:0] eg, ey, er;
        for (int c = 0; c < ncyc; c++) begin
            p = c % 9;
            q = c / 9;
            if (p == 0) begin
                eph = 2'd0; edir = 3'((q + 3) % 4); etim = 8'd0;
            end else if (p <= 6) begin
                eph = 2'd1; edir = 3'(q % 4); etim = 8'(p - 1);
            end else begin
                eph = 2'd2; edir = 3'(q % 4); etim = 8'(p - 7);
            end
            eg = (eph == 2'd1) ? (4'b0001 << edir) : 4'b0000;
            ey = (eph == 2'd2) ? (4'b0001 << edir) : 4'b0000;
            er = ~(eg | ey);
            n_cmp++;
            if (phase !== eph) begin
                n_err++;
                $display("FAIL %s phase cyc=%0d got=%0d exp=%0d", tag, c, phase, eph);
            end
            n_cmp++;
            if (active_dir !== edir) begin
                n_err++;
                $display("FAIL %s active_dir cyc=%0d got=%0d exp=%0d", tag, c, active_dir, edir);
            end
            n_cmp++;
            if (timer !== etim) begin
                n_err++;
                $display("FAIL %s timer cyc=%0d got=%0d exp=%0d", tag, c, timer, etim);
            end
            n_cmp++;
            if ({red, green, yellow} !== {er, eg, ey}) begin
                n_err++;
                $display("FAIL %s lamps cyc=%0d got r=%b g=%b y=%b exp r=%b g=%b y=%b",
                         tag, c, red, green, yellow, er, eg, ey);
            end
            step();
        end
    endtask

    task automatic test_reset();
        R = 1'b1; car = 4'b0; preempt_req = 1'b0; preempt_dir = 3'd0;
        #2;
        n_cmp++;
        if ({red, green, yellow} !== {4'b1111, 4'b0000, 4'b0000}) begin
            n_err++;
            $display("FAIL reset lamps got r=%b g=%b y=%b exp r=1111 g=0000 y=0000",
                     red, green, yellow);
        end
        n_cmp++;
        if ({phase, active_dir, timer} !== {2'd0, 3'd3, 8'd0}) begin
            n_err++;
            $display("FAIL reset state got ph=%0d dir=%0d t=%0d exp ph=0 dir=3 t=0",
                     phase, active_dir, timer);
        end
        step();
        step();
        n_cmp++;
        if ({phase, active_dir, timer, red} !== {2'd0, 3'd3, 8'd0, 4'b1111}) begin
            n_err++;
            $display("FAIL reset_held got ph=%0d dir=%0d t=%0d r=%b exp ph=0 dir=3 t=0 r=1111",
                     phase, active_dir, timer, red);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        run_rotation("rotation", 38);
    endtask

    task automatic test_demand_skip();
        logic [1:0] eph [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
        logic [7:0] etm [6] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd0, 8'd0};
        logic [2:0] edr [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
        do_reset();
        step();
        car = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++;
            if ({phase, timer, active_dir} !== {eph[k], etm[k], edr[k]}) begin
                n_err++;
                $display("FAIL demand_skip step=%0d got ph=%0d t=%0d dir=%0d exp ph=%0d t=%0d dir=%0d",
                         k, phase, timer, active_dir, eph[k], etm[k], edr[k]);
            end
        end
        n_cmp++;
        if ({green, red} !== {4'b0100, 4'b1011}) begin
            n_err++;
            $display("FAIL demand_skip lamps got g=%b r=%b exp g=0100 r=1011", green, red);
        end
    endtask

    task automatic test_own_car_only();
        do_reset();
        step();
        car = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++;
            if ({phase, timer, green} !== {2'd1, 8'(k), 4'b0001}) begin
                n_err++;
                $display("FAIL own_car green k=%0d got ph=%0d t=%0d g=%b exp ph=1 t=%0d g=0001",
                         k, phase, timer, green, k);
            end
        end
        step();
        n_cmp++;
        if ({phase, yellow} !== {2'd2, 4'b0001}) begin
            n_err++;
            $display("FAIL own_car yellow got ph=%0d y=%b exp ph=2 y=0001", phase, yellow);
        end
        step();
        step();
        n_cmp++;
        if ({phase, red} !== {2'd0, 4'b1111}) begin
            n_err++;
            $display("FAIL own_car allred got ph=%0d r=%b exp ph=0 r=1111", phase, red);
        end
        step();
        n_cmp++;
        if ({phase, active_dir, green} !== {2'd1, 3'd0, 4'b0001}) begin
            n_err++;
            $display("FAIL own_car regreen got ph=%0d dir=%0d g=%b exp ph=1 dir=0 g=0001",
                     phase, active_dir, green);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        repeat (10) step();
        n_cmp++;
        if ({phase, active_dir, timer} !== {2'd1, 3'd1, 8'd0}) begin
            n_err++;
            $display("FAIL preempt setup got ph=%0d dir=%0d t=%0d exp ph=1 dir=1 t=0",
                     phase, active_dir, timer);
        end
        preempt_req = 1'b1;
        preempt_dir = 3'd3;
        step();
        n_cmp++;
        if ({phase, yellow, timer} !== {2'd2, 4'b0010, 8'd0}) begin
            n_err++;
            $display("FAIL preempt yellow0 got ph=%0d y=%b t=%0d exp ph=2 y=0010 t=0",
                     phase, yellow, timer);
        end
        step();
        n_cmp++;
        if ({phase, yellow, timer} !== {2'd2, 4'b0010, 8'd1}) begin
            n_err++;
            $display("FAIL preempt yellow1 got ph=%0d y=%b t=%0d exp ph=2 y=0010 t=1",
                     phase, yellow, timer);
        end
        step();
        n_cmp++;
        if ({phase, active_dir} !== {2'd0, 3'd1}) begin
            n_err++;
            $display("FAIL preempt allred got ph=%0d dir=%0d exp ph=0 dir=1", phase, active_dir);
        end
        step();
        n_cmp++;
        if ({phase, active_dir, green} !== {2'd1, 3'd3, 4'b1000}) begin
            n_err++;
            $display("FAIL preempt green got ph=%0d dir=%0d g=%b exp ph=1 dir=3 g=1000",
                     phase, active_dir, green);
        end
        repeat (10) step();
        n_cmp++;
        if ({phase, timer} !== {2'd1, 8'd10}) begin
            n_err++;
            $display("FAIL preempt hold got ph=%0d t=%0d exp ph=1 t=10", phase, timer);
        end
        repeat (250) step();
        n_cmp++;
        if ({phase, timer} !== {2'd1, 8'd255}) begin
            n_err++;
            $display("FAIL preempt saturate got ph=%0d t=%0d exp ph=1 t=255", phase, timer);
        end
        step();
        n_cmp++;
        if (timer !== 8'd255) begin
            n_err++;
            $display("FAIL preempt no_wrap got t=%0d exp t=255", timer);
        end
        preempt_req = 1'b0;
    endtask

    task automatic test_bad_preempt();
        do_reset();
        preempt_req = 1'b1;
        preempt_dir = 3'd5;
        run_rotation("bad_preempt", 20);
        preempt_req = 1'b0;
    endtask

    task automatic test_reset_midphase();
        do_reset();
        repeat (8) step();
        n_cmp++;
        if ({phase, timer} !== {2'd2, 8'd1}) begin
            n_err++;
            $display("FAIL midreset setup got ph=%0d t=%0d exp ph=2 t=1", phase, timer);
        end
        R = 1'b1;
        #1;
        n_cmp++;
        if ({red, green, yellow, phase, timer, active_dir} !==
            {4'b1111, 4'b0000, 4'b0000, 2'd0, 8'd0, 3'd3}) begin
            n_err++;
            $display("FAIL midreset async got r=%b g=%b y=%b ph=%0d t=%0d dir=%0d",
                     red, green, yellow, phase, timer, active_dir);
        end
        step();
        R = 1'b0;
        run_rotation("after_reset", 11);
    endtask

    task automatic test_invariants();
        logic [1:0] prev_ph;
        logic [2:0] prev_dir;
        do_reset();
        prev_ph  = phase;
        prev_dir = active_dir;
        for (int c = 0; c < 300; c++) begin
            car         = 4'((c * 7) >> 3);
            preempt_req = ((c % 50) < 6);
            preempt_dir = 3'(c % 6);
            step();
            n_cmp++;
            if (((red ^ green ^ yellow) !== 4'b1111) ||
                (((red & green) | (red & yellow) | (green & yellow)) !== 4'b0000)) begin
                n_err++;
                $display("FAIL inv_one_lamp cyc=%0d got r=%b g=%b y=%b", c, red, green, yellow);
            end
            n_cmp++;
            if ($countones(~red) > 1) begin
                n_err++;
                $display("FAIL inv_non_red cyc=%0d got r=%b exp at most one clear", c, red);
            end
            n_cmp++;
            if (prev_ph == 2'd1 && phase == 2'd1 && active_dir !== prev_dir) begin
                n_err++;
                $display("FAIL inv_green_green cyc=%0d got dir=%0d exp dir=%0d",
                         c, active_dir, prev_dir);
            end
            prev_ph  = phase;
            prev_dir = active_dir;
        end
        car = 4'b0;
        preempt_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_demand_skip();
        test_own_car_only();
        test_preempt();
        test_bad_preempt();
        test_reset_midphase();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
